// File: rtl/netlist_gate_pkg.sv
// Shared types and helpers for the gated netlist pipeline: gate select encoding,
// the per-bit gate function and a population count.
package netlist_gate_pkg;

  localparam int unsigned MODE_W       = 2;
  localparam int unsigned POP_MAX_BITS = 1024;

  typedef enum logic [MODE_W-1:0] {
    GATE_AND  = 2'd0,
    GATE_NAND = 2'd1,
    GATE_OR   = 2'd2,
    GATE_XOR  = 2'd3
  } gate_mode_e;

  function automatic logic gate_apply(input gate_mode_e mode, input logic a, input logic b);
    logic y;
    y = 1'b0;
    case (mode)
      GATE_AND:  y = a & b;
      GATE_NAND: y = ~(a & b);
      GATE_OR:   y = a | b;
      GATE_XOR:  y = a ^ b;
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

  // Operands narrower than POP_MAX_BITS are zero-extended by the caller.
  function automatic int unsigned popcount(input logic [POP_MAX_BITS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_BITS; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/netlist_pipe_stage.sv
// One elastic pipeline slot: valid flag plus payload, loaded on 'load'.
// Payload only updates when a real beat arrives so bubbles leave data untouched.
module netlist_pipe_stage #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          in_valid,
  input  logic [PW-1:0] in_data,
  output logic          valid,
  output logic [PW-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (load && in_valid) begin
      data <= in_data;
    end
  end

endmodule

// File: rtl/netlist_gate_pipe.sv
// Multi-lane selectable bitwise gate feeding a DEPTH-stage valid/ready pipeline;
// each beat carries its result and ones-count computed ahead of stage 0.
module netlist_gate_pipe
  import netlist_gate_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 3
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [CHANNELS*WIDTH-1:0]             in_a,
  input  logic [CHANNELS*WIDTH-1:0]             in_b,
  input  logic [1:0]                            in_mode,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [CHANNELS*WIDTH-1:0]             out_y,
  output logic [$clog2(CHANNELS*WIDTH+1)-1:0]   out_ones
);

  localparam int unsigned N  = CHANNELS * WIDTH;
  localparam int unsigned OW = $clog2(N + 1);
  localparam int unsigned PW = N + OW;

  logic [N-1:0]    y_c;
  logic [OW-1:0]   ones_c;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] vin;
  logic [PW-1:0]   p   [DEPTH];
  logic [PW-1:0]   pin [DEPTH];

  // Lane packing is contiguous, so the gate is simply applied bit by bit.
  always_comb begin
    y_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      y_c[i] = gate_apply(gate_mode_e'(in_mode), in_a[i], in_b[i]);
    end
    ones_c = OW'(popcount(POP_MAX_BITS'(y_c)));
  end

  // Stage g can move when downstream pops or any slot from g onward is empty;
  // this is the unrolled form of r[i] = ~v[i] | r[i+1].
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    assign r[g] = out_ready | ~(&v[DEPTH-1:g]);

    if (g == 0) begin : g_head
      assign vin[g] = in_valid;
      assign pin[g] = {ones_c, y_c};
    end else begin : g_body
      assign vin[g] = v[g-1];
      assign pin[g] = p[g-1];
    end

    netlist_pipe_stage #(
      .PW(PW)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (r[g]),
      .in_valid (vin[g]),
      .in_data  (pin[g]),
      .valid    (v[g]),
      .data     (p[g])
    );
  end

  assign in_ready  = r[0];
  assign out_valid = v[DEPTH-1];
  assign out_y     = p[DEPTH-1][N-1:0];
  assign out_ones  = p[DEPTH-1][PW-1:N];

endmodule

// File: tb/tb_netlist_gate_pipe.sv
// Directed and randomised checks of netlist_gate_pipe: default 2x4x3 pipe plus
// 1x1x1 and 4x8x3 corner instances.
module tb_netlist_gate_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance: CHANNELS=2 WIDTH=4 DEPTH=3
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_a, in_b, out_y;
  logic [1:0] in_mode;
  logic [3:0] out_ones;

  // corner: CHANNELS=1 WIDTH=1 DEPTH=1
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [0:0] c_in_a, c_in_b, c_out_y, c_out_ones;
  logic [1:0] c_in_mode;

  // corner: CHANNELS=4 WIDTH=8 DEPTH=3
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [31:0] w_in_a, w_in_b, w_out_y;
  logic [1:0]  w_in_mode;
  logic [5:0]  w_out_ones;

  netlist_gate_pipe #(.WIDTH(4), .CHANNELS(2), .DEPTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_ones(out_ones));

  netlist_gate_pipe #(.WIDTH(1), .CHANNELS(1), .DEPTH(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_a(c_in_a), .in_b(c_in_b), .in_mode(c_in_mode), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_y(c_out_y), .out_ones(c_out_ones));

  netlist_gate_pipe #(.WIDTH(8), .CHANNELS(4), .DEPTH(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_a(w_in_a), .in_b(w_in_b), .in_mode(w_in_mode), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .out_y(w_out_y), .out_ones(w_out_ones));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference result {ones, y} for the 8-bit default instance
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] m);
    logic [7:0] y;
    case (m)
      2'd0:    y = a & b;
      2'd1:    y = ~(a & b);
      2'd2:    y = a | b;
      default: y = a ^ b;
    endcase
    return {4'($countones(y)), y};
  endfunction

  logic [11:0] q[$];
  logic [11:0] exp_beat;
  logic [11:0] held;
  logic        acc, stall;
  int          sent, cyc;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_mode = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_in_a = '0; c_in_b = '0; c_in_mode = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_in_a = '0; w_in_b = '0; w_in_mode = '0;

    // reset state
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_y",     64'(out_y),     64'(0));
    chk("rst_out_ones",  64'(out_ones),  64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // modes back-to-back, a=C5 b=A3
    in_a = 8'hC5; in_b = 8'hA3; in_mode = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick(); in_mode = 2'd1;
    tick(); chk("lat_not_early", 64'(out_valid), 64'(0)); in_mode = 2'd2;
    tick(); chk("and_valid", 64'(out_valid), 64'(1));
    chk("and_y", 64'(out_y), 64'(8'h81)); chk("and_ones", 64'(out_ones), 64'(2));
    in_mode = 2'd3;
    tick(); chk("nand_y", 64'(out_y), 64'(8'h7E)); chk("nand_ones", 64'(out_ones), 64'(6));
    in_valid = 1'b0;
    tick(); chk("or_y", 64'(out_y), 64'(8'hE7)); chk("or_ones", 64'(out_ones), 64'(6));
    tick(); chk("xor_y", 64'(out_y), 64'(8'h66)); chk("xor_ones", 64'(out_ones), 64'(4));
    tick(); chk("modes_drained", 64'(out_valid), 64'(0));

    // backpressure: OR with b=0 passes a through
    out_ready = 1'b0; in_b = 8'h00; in_mode = 2'd2; in_valid = 1'b1;
    in_a = 8'h11; #1; chk("bp_rdy0", 64'(in_ready), 64'(1));
    tick(); in_a = 8'h3C; #1; chk("bp_rdy1", 64'(in_ready), 64'(1));
    tick(); in_a = 8'hF0; #1; chk("bp_rdy2", 64'(in_ready), 64'(1));
    tick(); in_a = 8'hFF; #1; chk("bp_full", 64'(in_ready), 64'(0));
    tick();
    chk("bp_hold_rdy", 64'(in_ready), 64'(0));
    chk("bp_hold_valid", 64'(out_valid), 64'(1));
    chk("bp_hold_y", 64'(out_y), 64'(8'h11));
    out_ready = 1'b1; #1;
    chk("bp_pop_push_rdy", 64'(in_ready), 64'(1));
    tick(); in_valid = 1'b0;
    chk("bp_y1", 64'(out_y), 64'(8'h3C)); chk("bp_o1", 64'(out_ones), 64'(4));
    tick(); chk("bp_y2", 64'(out_y), 64'(8'hF0)); chk("bp_o2", 64'(out_ones), 64'(4));
    tick(); chk("bp_y3", 64'(out_y), 64'(8'hFF)); chk("bp_o3", 64'(out_ones), 64'(8));
    tick(); chk("bp_drained", 64'(out_valid), 64'(0));

    // reset with three beats in flight
    out_ready = 1'b0; in_a = 8'h5A; in_b = 8'h0F; in_mode = 2'd3; in_valid = 1'b1;
    tick(); tick(); tick(); in_valid = 1'b0;
    chk("mid_full", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_y",     64'(out_y),     64'(0));
    chk("mid_rst_ones",  64'(out_ones),  64'(0));
    tick(); rst_n = 1'b1;
    tick();
    chk("mid_rel_rdy",   64'(in_ready),  64'(1));
    chk("mid_rel_valid", 64'(out_valid), 64'(0));

    // random valid/ready with scoreboard and stall stability
    sent = 0; cyc = 0; acc = 1'b0; stall = 1'b0; held = '0;
    in_valid = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      if (stall) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_data", 64'({out_ones, out_y}), 64'(held));
      end
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid || acc) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_mode  = 2'($urandom_range(0, 3));
      end
      #1;
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(in_a, in_b, in_mode));
        sent++;
      end
      if (out_valid && out_ready) begin
        exp_beat = (q.size() > 0) ? q.pop_front() : 12'hFFF;
        chk("rand_beat", 64'({out_ones, out_y}), 64'(exp_beat));
      end
      stall = out_valid && !out_ready;
      held  = {out_ones, out_y};
      tick();
      cyc++;
    end
    chk("rand_sent", 64'(sent), 64'(1000));
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      if (out_valid) begin
        exp_beat = q.pop_front();
        chk("drain_beat", 64'({out_ones, out_y}), 64'(exp_beat));
      end
      tick();
    end
    chk("rand_queue_empty", 64'(q.size()), 64'(0));
    tick();
    chk("rand_final_idle", 64'(out_valid), 64'(0));

    // corners
    c_in_a = 1'b1; c_in_b = 1'b1; c_in_mode = 2'd0; c_in_valid = 1'b1;
    w_in_a = '0; w_in_b = '0; w_in_mode = 2'd1; w_in_valid = 1'b1;
    #1; chk("c_in_ready", 64'(c_in_ready), 64'(1));
    tick(); c_in_valid = 1'b0; w_in_valid = 1'b0;
    chk("c_valid", 64'(c_out_valid), 64'(1));
    chk("c_y",     64'(c_out_y),     64'(1));
    chk("c_ones",  64'(c_out_ones),  64'(1));
    chk("w_not_early", 64'(w_out_valid), 64'(0));
    tick(); tick();
    chk("w_valid", 64'(w_out_valid), 64'(1));
    chk("w_y",     64'(w_out_y),     64'(32'hFFFF_FFFF));
    chk("w_ones",  64'(w_out_ones),  64'(32));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/netlist_gate_pipe.md
Name:
netlist_gate_pipe

Overview:
- Parametrised, pipelined successor to the single-bit gated-AND netlist primitive.
- Applies a selectable bitwise gate function (AND/NAND/OR/XOR) across CHANNELS lanes of WIDTH bits each.
- Pushes results through a DEPTH-stage elastic valid/ready pipeline with full backpressure, plus a per-beat ones-count.
- Sits between fake-netlist stimulus generators and sequential-netlist characterisation harnesses.

Parameters:
- WIDTH, 4, bits per channel (>=1).
- CHANNELS, 2, number of independent lanes (>=1).
- DEPTH, 3, pipeline register stages (>=1); this is also the latency in cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  pipeline can accept a beat this cycle.
- in_a  input  CHANNELS*WIDTH  operand A; channel c occupies bits [c*WIDTH +: WIDTH].
- in_b  input  CHANNELS*WIDTH  operand B, same packing as in_a.
- in_mode  input  2  gate select, sampled with the beat.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts.
- out_y  output  CHANNELS*WIDTH  gated result.
- out_ones  output  $clog2(CHANNELS*WIDTH+1)  population count of out_y.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n. Assertion is immediate; deassertion is synchronous to clk.
- Reset values: every stage valid=0, every stage data=0. Hence out_valid=0, out_y=0, out_ones=0. in_ready=1 as soon as reset deasserts.
- Gate function, evaluated combinationally before stage 0, bitwise on in_a/in_b:
  - mode 0: A&B
  - mode 1: ~(A&B)
  - mode 2: A|B
  - mode 3: A^B
- The ones-count is computed before stage 0 and travels with the data. No arithmetic occurs downstream.
- Stage i holds valid v[i] and payload p[i]. Stage DEPTH-1 drives the outputs directly.
- Ready chain:
  - r[DEPTH-1] = ~v[DEPTH-1] | out_ready
  - r[i] = ~v[i] | r[i+1]
  - in_ready = r[0]
  - The chain is combinational. No skid buffers.
- Transfer rule: stage i loads when r[i]=1.
  - Stage 0 loads in_valid and the computed payload.
  - Stage i>0 loads v[i-1] and p[i-1].
  - If r[i]=0, the stage holds.
  - Payload registers load only when the incoming valid=1. Bubbles do not toggle data (power rule).
- Latency: a beat accepted at edge k appears on the outputs after edge k+DEPTH-1 when there is no stall. Throughput is 1 beat/cycle with out_ready held high.
- Input handshake: a beat is accepted on an edge with in_valid&in_ready.
  - The source must hold in_a, in_b and in_mode stable while in_valid=1 and in_ready=0.
  - The block does not check this.
- Output stability: while out_valid=1 and out_ready=0, out_y and out_ones hold stable. Every stage fills in turn; when full, in_ready=0.
- Simultaneous pop and push with the pipe full: in_ready=1 in the same cycle, and the beat is accepted with no bubble.
- Ordering: beats emerge in acceptance order. No drop, no duplication.
- Reset mid-operation: all in-flight beats are discarded and out_valid falls immediately (asynchronously).
- Mode changes between beats are allowed every cycle. Each beat carries its own result.

Decomposition:
- Package netlist_gate_pkg:
  - gate_mode_e enum: GATE_AND=0, GATE_NAND=1, GATE_OR=2, GATE_XOR=3.
  - function gate_apply(mode, a, b).
  - function popcount.
- One sub-module, netlist_pipe_stage: a single valid/payload register with load/hold, parametrised on payload width. The top instantiates DEPTH of these via generate and holds the gate logic and ready chain.

Test Plan (CHANNELS=2, WIDTH=4, DEPTH=3 unless stated):
- Reset: drive rst_n=0 mid-stream with 3 beats in flight -> out_valid=0, out_y=0x00 and out_ones=0 immediately; in_ready=1 one cycle after release.
- Modes: in_a=0xC5, in_b=0xA3, modes 0..3 back-to-back with out_ready=1 -> out_y 0x81 (ones 2), 0x7E (6), 0xE7 (6), 0x66 (4). First result appears 3 cycles after the first accept; then one per cycle.
- Backpressure: out_ready=0, 4 beats offered -> exactly 3 accepted and in_ready=0. Raising out_ready drains all three in order while the 4th is accepted in the same cycle.
- Random stalls: 1000 random beats with random in_valid/out_ready at 50% each -> scoreboard matches gate_apply results in order, and out_y stays stable during every stall.
- Corners: CHANNELS=1, WIDTH=1, DEPTH=1 with a=1, b=1, mode 0 -> out_y=1, out_ones=1 on the cycle after accept. CHANNELS=4, WIDTH=8, mode 1, all-zeros operands -> out_ones=32.
